// File: rtl/cache_miss_ctrl_if.sv
// Core/cache/memory signal bundle for the miss controller.
// master = controller view, slave = core, cache and memory view.
interface cache_miss_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_rd_en;
  logic                  cpu_wr_en;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic                  stall;
  logic                  cache_hit;
  logic                  victim_dirty;
  logic [DATA_WIDTH-1:0] victim_addr;
  logic                  wb_en;
  logic                  refill_en;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_ready;

  modport master (
    input  cpu_rd_en, cpu_wr_en, cpu_addr, cache_hit, victim_dirty, victim_addr, mem_ready,
    output stall, wb_en, refill_en, mem_req, mem_we, mem_addr
  );

  modport slave (
    output cpu_rd_en, cpu_wr_en, cpu_addr, cache_hit, victim_dirty, victim_addr, mem_ready,
    input  stall, wb_en, refill_en, mem_req, mem_we, mem_addr
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Data-cache miss sequencer: stalls the core, writes back a dirty victim, then refills.
// Define CACHE_PERF_CNT_EN to build the saturating hit/miss/write-back counters.
module cache_miss_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_BYTES = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_miss_ctrl_if.master    bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(BLOCK_BYTES - 1));

  typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] miss_addr;
  logic                  access;
  logic                  miss;
  logic                  mem_done;

  assign access   = bus.cpu_rd_en | bus.cpu_wr_en;
  assign miss     = (state == IDLE) & access & ~bus.cache_hit;
  // A ready pulse only counts while a request is actually outstanding.
  assign mem_done = bus.mem_req & bus.mem_ready;

  assign bus.stall     = (state != IDLE) | miss;
  assign bus.refill_en = (state == REFILL) & mem_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.mem_req  <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.wb_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            bus.mem_req <= 1'b1;
            if (bus.victim_dirty) begin
              state        <= WB;
              bus.mem_we   <= 1'b1;
              bus.wb_en    <= 1'b1;
              bus.mem_addr <= bus.victim_addr & ALIGN_MASK;
            end else begin
              state        <= REFILL;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= bus.cpu_addr & ALIGN_MASK;
            end
          end
        end
        WB: begin
          // Request stays up: write-back flows straight into the refill read.
          if (mem_done) begin
            state        <= REFILL;
            bus.mem_we   <= 1'b0;
            bus.wb_en    <= 1'b0;
            bus.mem_addr <= miss_addr;
          end
        end
        REFILL: begin
          if (mem_done) begin
            state        <= DONE;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (miss) miss_addr <= bus.cpu_addr & ALIGN_MASK;
  end

`ifdef CACHE_PERF_CNT_EN
  logic relook;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // relook marks the first IDLE cycle after DONE, where the refilled line is re-probed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relook     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      relook <= (state == DONE);
      if ((state == IDLE) && access && bus.cache_hit && !relook) hit_count <= sat_inc(hit_count);
      if (miss) miss_count <= sat_inc(miss_count);
      if ((state == WB) && mem_done) wb_count <= sat_inc(wb_count);
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: expected memory transfers are queued at stimulus
// time and popped when the DUT completes a transfer; counters follow a saturating model.
module tb_cache_miss_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] wb_count;

  int n_checks;
  int n_fail;
  int exp_hit;
  int exp_miss;
  int exp_wb;

  typedef struct {
    logic        we;
    logic [31:0] addr;
  } xfer_t;

  xfer_t sb[$];

  cache_miss_ctrl_if #(.DATA_WIDTH(32)) bus ();

  cache_miss_ctrl #(
    .DATA_WIDTH (32),
    .BLOCK_BYTES(16),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .hit_count (hit_count),
    .miss_count(miss_count),
    .wb_count  (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [63:0] cnt_exp(input int v);
`ifdef CACHE_PERF_CNT_EN
    return 64'(v);
`else
    return (v > 0) ? 64'd0 : 64'd0;
`endif
  endfunction

  task automatic check_counters(input string tag);
    check_val({tag, "_hit_count"},  hit_count,  cnt_exp(exp_hit));
    check_val({tag, "_miss_count"}, miss_count, cnt_exp(exp_miss));
    check_val({tag, "_wb_count"},   wb_count,   cnt_exp(exp_wb));
  endtask

  task automatic idle_inputs();
    bus.cpu_rd_en    = 1'b0;
    bus.cpu_wr_en    = 1'b0;
    bus.cache_hit    = 1'b0;
    bus.victim_dirty = 1'b0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic do_hit(input logic rd, input logic wr, input logic [31:0] addr);
    @(posedge clk); #1;
    bus.cpu_rd_en = rd;
    bus.cpu_wr_en = wr;
    bus.cpu_addr  = addr;
    bus.cache_hit = 1'b1;
    @(negedge clk);
    check_val("hit_stall",    bus.stall,    0);
    check_val("hit_mem_req",  bus.mem_req,  0);
    check_val("hit_mem_addr", bus.mem_addr, 0);
    exp_hit = sat(exp_hit);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_val("hit_count_after", hit_count, cnt_exp(exp_hit));
  endtask

  // Miss cycle is cycle 0; memory answers on the lw-th / lr-th cycle of each request.
  task automatic do_miss(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic dirty, input logic [31:0] vaddr,
                         input int lw, input int lr, input int exp_stall);
    int    stall_n;
    int    refill_n;
    int    refill_at;
    int    cnt;
    bit    done;
    xfer_t x;
    if (dirty) sb.push_back('{1'b1, vaddr & ~32'hF});
    sb.push_back('{1'b0, addr & ~32'hF});
    @(posedge clk); #1;
    bus.cpu_rd_en    = rd;
    bus.cpu_wr_en    = wr;
    bus.cpu_addr     = addr;
    bus.cache_hit    = 1'b0;
    bus.victim_dirty = dirty;
    bus.victim_addr  = vaddr;
    bus.mem_ready    = 1'b0;
    cnt = 0; stall_n = 0; refill_n = 0; refill_at = -1; done = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        if (bus.mem_req) begin
          cnt++;
          bus.mem_ready = (cnt == (bus.mem_we ? lw : lr));
          if (bus.mem_ready) cnt = 0;
        end else begin
          bus.mem_ready = 1'b0;
        end
        if (refill_n > 0) bus.cache_hit = 1'b1;
      end
      @(negedge clk);
      if (bus.stall) stall_n++;
      else done = 1;
      if (bus.mem_req && bus.mem_ready) begin
        if (sb.size() == 0) begin
          check_val("sb_underflow", sb.size(), 1);
        end else begin
          x = sb.pop_front();
          check_val("xfer_we",    bus.mem_we,   x.we);
          check_val("xfer_addr",  bus.mem_addr, x.addr);
          check_val("xfer_wb_en", bus.wb_en,    x.we);
        end
      end
      if (bus.refill_en) begin
        refill_n++;
        refill_at = cyc;
      end
    end
    check_val("miss_done",     done,      1);
    check_val("stall_cycles",  stall_n,   exp_stall);
    check_val("refill_pulses", refill_n,  1);
    check_val("refill_cycle",  refill_at, exp_stall - 2);
    check_val("sb_empty",      sb.size(), 0);
    exp_miss = sat(exp_miss);
    if (dirty) exp_wb = sat(exp_wb);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_counters("miss");
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    rst_n = 1'b0;
    bus.cpu_addr    = '0;
    bus.victim_addr = '0;
    idle_inputs();
    #22;
    check_val("rst_stall",     bus.stall,     0);
    check_val("rst_mem_req",   bus.mem_req,   0);
    check_val("rst_mem_we",    bus.mem_we,    0);
    check_val("rst_mem_addr",  bus.mem_addr,  0);
    check_val("rst_wb_en",     bus.wb_en,     0);
    check_val("rst_refill_en", bus.refill_en, 0);
    check_counters("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_hit(1'b1, 1'b0, 32'h0000_0040);
    do_hit(1'b0, 1'b1, 32'h0000_0084);

    do_miss(1'b1, 1'b0, 32'h0000_1234, 1'b0, 32'h0,         0, 3, 5);
    do_miss(1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'h0000_2230, 2, 2, 6);
    do_miss(1'b1, 1'b1, 32'h0000_5678, 1'b0, 32'h0,         0, 1, 3);
    do_miss(1'b0, 1'b1, 32'h0000_9ABC, 1'b1, 32'h0000_733F, 1, 4, 7);

    // Reset mid-refill: request must vanish immediately and a stray ready is ignored.
    @(posedge clk); #1;
    bus.cpu_rd_en    = 1'b1;
    bus.cpu_addr     = 32'h0000_4444;
    bus.cache_hit    = 1'b0;
    bus.victim_dirty = 1'b0;
    @(posedge clk); #1;
    check_val("abort_req_before", bus.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_mem_req",   bus.mem_req,   0);
    check_val("abort_mem_addr",  bus.mem_addr,  0);
    check_val("abort_refill_en", bus.refill_en, 0);
    check_val("abort_redetect",  bus.stall,     1);
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    check_counters("abort");
    bus.cpu_rd_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check_val("stray_ready_refill_en", bus.refill_en, 0);
    check_val("stray_ready_mem_req",   bus.mem_req,   0);
    check_val("stray_ready_stall",     bus.stall,     0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_val("stray_ready_idle", bus.mem_req, 0);

    do_miss(1'b1, 1'b0, 32'h0000_4444, 1'b0, 32'h0, 0, 2, 4);

    // 17 back-to-back hit cycles drive hit_count into saturation.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      bus.cpu_rd_en = 1'b1;
      bus.cpu_addr  = 32'h0000_0100 + 32'(i * 4);
      bus.cache_hit = 1'b1;
      exp_hit = sat(exp_hit);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_val("sat_hit_count", hit_count, cnt_exp(exp_hit));
    check_counters("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Miss-handling controller for the data-memory subsystem. It detects data-cache misses, stalls the core, and sequences the block transfers between the cache and the backing data memory: an optional dirty-victim write-back, then a block refill. It sits between the core's load/store signals, the cache's hit/victim status and a multi-cycle data memory that uses a req/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, address and data word width
- BLOCK_BYTES, 16, cache block size in bytes (power of two); memory addresses are aligned to it
- CNT_WIDTH, 32, width of the performance counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_rd_en  in  1  load access this cycle
- cpu_wr_en  in  1  store access this cycle
- cpu_addr  in  DATA_WIDTH  byte address of the access
- stall  out  1  freezes the core pipeline
- cache_hit  in  1  cache lookup hit for cpu_addr
- victim_dirty  in  1  the line that would be replaced is valid and dirty
- victim_addr  in  DATA_WIDTH  base address of that line
- wb_en  out  1  cache drives the victim block onto the memory write bus
- refill_en  out  1  one-cycle pulse: cache writes the memory read block into the line and marks it clean and valid
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = block write, 0 = block read (valid while mem_req is high)
- mem_addr  out  DATA_WIDTH  block-aligned memory address
- mem_ready  in  1  memory has completed the current request (single-cycle pulse)
- hit_count, miss_count, wb_count  out  CNT_WIDTH  performance counters

## Operation
- States: IDLE, WB, REFILL, DONE.
- access = cpu_rd_en | cpu_wr_en. If both are high in the same cycle, they are treated as one access.
- IDLE:
  - If access & ~cache_hit: latch miss_addr = cpu_addr & ~(BLOCK_BYTES-1) and victim_addr.
  - Then go to WB if victim_dirty, otherwise to REFILL.
  - If access & cache_hit: stay in IDLE.
- WB: mem_req=1, mem_we=1, mem_addr=latched victim_addr (aligned), wb_en=1. On mem_ready, go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr=miss_addr. On mem_ready, assert refill_en for that same cycle, then go to DONE.
- DONE: no memory request. Always go to IDLE next cycle. There the access is re-evaluated and must hit.
- stall:
  - Combinational (access & ~cache_hit) in IDLE.
  - 1 in WB, REFILL and DONE.
- mem_ready is ignored while mem_req=0.
- mem_addr is 0 when mem_req=0.
- Inputs other than mem_ready are ignored outside IDLE; the core is stalled, so they are held.

## Timing
- Reset (async assert, sync release): state=IDLE. All outputs 0: mem_req, mem_we, mem_addr, wb_en, refill_en, counters. stall follows its IDLE equation.
- Clean miss: stall high from the miss cycle. REFILL begins in cycle +1. With memory latency L cycles from mem_req to mem_ready, refill_en pulses in cycle +L. DONE is cycle +L+1. stall drops in cycle +L+2 (hit in IDLE).
- Dirty miss: add Lw (write latency) cycles of WB before REFILL. mem_req stays high without a gap between WB and REFILL only if mem_ready is in the last WB cycle; mem_we changes 1→0 at the transition.
- mem_ready in the same cycle that mem_req first rises (L=0) completes the phase immediately.
- Reset asserted mid-transfer: mem_req drops immediately (async). No refill_en is issued. The miss is re-detected after reset release.

## Configuration
- CACHE_PERF_CNT_EN defined:
  - hit_count +1 per IDLE cycle with access & cache_hit, excluding the post-DONE re-lookup.
  - miss_count +1 per IDLE→WB/REFILL transition.
  - wb_count +1 per WB completion.
  - All counters saturate at all-ones.
- Not defined: counter logic is removed, and the counter outputs are tied to 0 (ports remain).

## Test plan
- Read hit: cpu_rd_en=1, cache_hit=1 → stall=0, mem_req=0, hit_count 0→1.
- Clean miss, L=3, cpu_addr=0x0000_1234 → mem_addr=0x0000_1230, mem_we=0. refill_en pulses in cycle 3; stall is high for 5 cycles; miss_count=1.
- Dirty miss, victim_addr=0x0000_2230, Lw=2, L=2 → write to 0x2230 with wb_en=1, then read 0x1230. wb_count=1; stall lasts 2+2+2 = 6 cycles (miss cycle, WB, REFILL, DONE).
- Simultaneous cpu_rd_en=cpu_wr_en=1 on a miss → exactly one refill sequence and miss_count +1.
- rst_n pulled low during REFILL, before mem_ready → mem_req=0 and state=IDLE immediately. No refill_en, and a later mem_ready is ignored.
- Counter saturation (CNT_WIDTH=4): 17 hits → hit_count stays 15. With CACHE_PERF_CNT_EN undefined → all counters stay 0.
